// File: rtl/addr_record_pkg.sv
// Shared definitions for the 10-bit address record: field positions, the packed
// record layout, the 9-bit stored entry, and a helper that builds a record word.
package addr_record_pkg;

    localparam int RECORD_W = 10;
    localparam int ADDR_MSB = 9;
    localparam int ADDR_LSB = 2;
    localparam int AV_BIT   = 1;
    localparam int V_BIT    = 0;
    localparam int ADDR_W   = ADDR_MSB - ADDR_LSB + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic              address_valid;
        logic              valid;
    } record_t;

    // The valid bit is implied by presence in the FIFO, so only 9 bits are stored.
    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic              address_valid;
    } entry_t;

    function automatic logic [RECORD_W-1:0] pack_record(
        input logic [ADDR_W-1:0] address,
        input logic              address_valid,
        input logic              valid
    );
        record_t r;
        r.address       = address;
        r.address_valid = address_valid;
        r.valid         = valid;
        return r;
    endfunction

endpackage

// File: rtl/addr_record_fifo.sv
// Circular-buffer FIFO of address entries; occupancy is tracked by an explicit
// level counter so full and empty never depend on pointer equality alone.
module addr_record_fifo
    import addr_record_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  entry_t           din,
    output entry_t           dout,
    output logic             empty,
    output logic             push_ok,
    output logic [LVL_W-1:0] level
);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             full;
    logic             pop_ok;

    // A pop frees the head slot in the same edge, so a full FIFO can still accept.
    always_comb begin
        empty   = (level == '0);
        full    = (level == LVL_W'(DEPTH));
        pop_ok  = pop & ~empty;
        push_ok = push & (~full | pop_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                level <= level + LVL_W'(1);
            end else if (pop_ok && !push_ok) begin
                level <= level - LVL_W'(1);
            end
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/addr_record_receiver.sv
// Receives packed address records into a FIFO, presents the head entry
// downstream, and keeps saturating counts of dropped and address-less records.
module addr_record_receiver
    import addr_record_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    CE,
    input  logic [RECORD_W-1:0]     I,
    output logic [ADDR_W-1:0]       O_address,
    output logic                    O_addressValid,
    output logic                    O_valid,
    input  logic                    O_ready,
    output logic [$clog2(DEPTH):0]  level,
    output logic [CNT_W-1:0]        overflow_count,
    output logic [CNT_W-1:0]        noaddr_count
);

    // Handshake: a head entry transfers on an enabled edge where O_valid and
    // O_ready are both 1; O_valid never depends on O_ready or on I.
    record_t rec;
    entry_t  head;
    entry_t  din;
    logic    push_req;
    logic    pop_req;
    logic    push_ok;
    logic    empty;

    always_comb begin
        rec.address       = I[ADDR_MSB:ADDR_LSB];
        rec.address_valid = I[AV_BIT];
        rec.valid         = I[V_BIT];
        din.address       = rec.address;
        din.address_valid = rec.address_valid;
        push_req          = CE & rec.valid;
        pop_req           = CE & O_ready;
    end

    addr_record_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RESET),
        .push    (push_req),
        .pop     (pop_req),
        .din     (din),
        .dout    (head),
        .empty   (empty),
        .push_ok (push_ok),
        .level   (level)
    );

    assign O_address      = head.address;
    assign O_addressValid = head.address_valid;
    assign O_valid        = ~empty;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            overflow_count <= '0;
            noaddr_count   <= '0;
        end else begin
            if (push_req && !push_ok && overflow_count != '1) begin
                overflow_count <= overflow_count + CNT_W'(1);
            end
            if (push_ok && !rec.address_valid && noaddr_count != '1) begin
                noaddr_count <= noaddr_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_addr_record_receiver.sv
// Bench for addr_record_receiver: two instances (CNT_W=8 and CNT_W=2) share stimulus
// and are checked against a queue-based model plus a table of directed vectors.
module tb_addr_record_receiver;

    localparam int DEPTH = 4;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       CE = 1'b0;
    logic [9:0] I = '0;
    logic       O_ready = 1'b0;

    logic [7:0] addr_a, addr_b;
    logic       av_a, av_b, v_a, v_b;
    logic [2:0] lvl_a, lvl_b;
    logic [7:0] ovf_a, nad_a;
    logic [1:0] ovf_b, nad_b;

    int errors = 0;
    int checks = 0;

    logic [8:0] exp_q[$];
    int ovf_raw = 0;
    int nad_raw = 0;

    always #5 CLK = ~CLK;

    addr_record_receiver #(.DEPTH(DEPTH), .CNT_W(8)) dut_a (
        .CLK(CLK), .RESET(RESET), .CE(CE), .I(I),
        .O_address(addr_a), .O_addressValid(av_a), .O_valid(v_a), .O_ready(O_ready),
        .level(lvl_a), .overflow_count(ovf_a), .noaddr_count(nad_a)
    );

    addr_record_receiver #(.DEPTH(DEPTH), .CNT_W(2)) dut_b (
        .CLK(CLK), .RESET(RESET), .CE(CE), .I(I),
        .O_address(addr_b), .O_addressValid(av_b), .O_valid(v_b), .O_ready(O_ready),
        .level(lvl_b), .overflow_count(ovf_b), .noaddr_count(nad_b)
    );

    function automatic logic [9:0] mk(input logic [7:0] a, input logic av, input logic v);
        return {a, av, v};
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Reference behaviour: pop sees the pre-edge contents, push is accepted when
    // there was room or when this same edge frees a slot.
    task automatic model_edge(input logic ce, input logic rst, input logic [9:0] i,
                              input logic ready);
        int  pre;
        bit  do_pop;
        if (rst) begin
            exp_q.delete();
            ovf_raw = 0;
            nad_raw = 0;
        end else if (ce) begin
            pre    = exp_q.size();
            do_pop = (pre > 0) && ready;
            if (do_pop) void'(exp_q.pop_front());
            if (i[0]) begin
                if (pre < DEPTH || do_pop) begin
                    exp_q.push_back(i[9:1]);
                    if (!i[1]) nad_raw++;
                end else begin
                    ovf_raw++;
                end
            end
        end
    endtask

    task automatic check_model(input logic was_rst);
        check("m_valid_a", v_a, exp_q.size() != 0);
        check("m_valid_b", v_b, exp_q.size() != 0);
        check("m_level_a", lvl_a, exp_q.size());
        check("m_level_b", lvl_b, exp_q.size());
        check("m_ovf_a", ovf_a, sat(ovf_raw, 255));
        check("m_ovf_b", ovf_b, sat(ovf_raw, 3));
        check("m_noaddr_a", nad_a, sat(nad_raw, 255));
        check("m_noaddr_b", nad_b, sat(nad_raw, 3));
        if (exp_q.size() != 0) begin
            check("m_addr_a", addr_a, exp_q[0][8:1]);
            check("m_addr_b", addr_b, exp_q[0][8:1]);
            check("m_av_a", av_a, exp_q[0][0]);
            check("m_av_b", av_b, exp_q[0][0]);
        end else if (was_rst) begin
            check("m_rst_addr_a", addr_a, 0);
            check("m_rst_addr_b", addr_b, 0);
            check("m_rst_av_a", av_a, 0);
            check("m_rst_av_b", av_b, 0);
        end
    endtask

    task automatic step(input logic ce, input logic rst, input logic [9:0] i,
                        input logic ready);
        @(negedge CLK);
        CE = ce; RESET = rst; I = i; O_ready = ready;
        @(posedge CLK);
        model_edge(ce, rst, i, ready);
        #1;
        check_model(rst);
    endtask

    typedef struct {
        logic       ce;
        logic       rst;
        logic [9:0] i;
        logic       ready;
        logic       ev;
        logic [7:0] ea;
        logic       eav;
        int         el;
        int         eo;
        int         en;
    } vec_t;

    vec_t vt[$];

    initial begin
        vec_t v;
        logic [7:0] order[4];

        // ce rst i ready | valid addr av level ovf noaddr
        vt.push_back('{1, 1, 10'h000,          0, 0, 8'h00, 0, 0, 0, 0});
        vt.push_back('{1, 0, 10'h3FF,          0, 1, 8'hFF, 1, 1, 0, 0});
        vt.push_back('{0, 1, mk(8'hAA, 1, 1),  1, 0, 8'h00, 0, 0, 0, 0});
        vt.push_back('{1, 0, mk(8'h01, 1, 1),  0, 1, 8'h01, 1, 1, 0, 0});
        vt.push_back('{1, 0, mk(8'h02, 1, 1),  0, 1, 8'h01, 1, 2, 0, 0});
        vt.push_back('{1, 0, mk(8'h03, 1, 1),  0, 1, 8'h01, 1, 3, 0, 0});
        vt.push_back('{1, 0, mk(8'h04, 1, 1),  0, 1, 8'h01, 1, 4, 0, 0});
        vt.push_back('{1, 0, mk(8'h05, 1, 1),  0, 1, 8'h01, 1, 4, 1, 0});
        vt.push_back('{1, 0, mk(8'h09, 1, 1),  1, 1, 8'h02, 1, 4, 1, 0});
        vt.push_back('{1, 0, 10'h000,          1, 1, 8'h03, 1, 3, 1, 0});
        vt.push_back('{1, 0, 10'h000,          1, 1, 8'h04, 1, 2, 1, 0});
        vt.push_back('{1, 0, 10'h000,          1, 1, 8'h09, 1, 1, 1, 0});
        vt.push_back('{1, 0, 10'h000,          1, 0, 8'h00, 0, 0, 1, 0});
        vt.push_back('{1, 0, mk(8'h22, 0, 1),  0, 1, 8'h22, 0, 1, 1, 1});
        vt.push_back('{0, 0, mk(8'h33, 1, 1),  1, 1, 8'h22, 0, 1, 1, 1});
        vt.push_back('{0, 0, mk(8'h33, 0, 1),  1, 1, 8'h22, 0, 1, 1, 1});
        vt.push_back('{0, 0, mk(8'h34, 1, 1),  1, 1, 8'h22, 0, 1, 1, 1});
        vt.push_back('{1, 0, mk(8'h44, 1, 0),  1, 0, 8'h00, 0, 0, 1, 1});

        for (int n = 0; n < vt.size(); n++) begin
            v = vt[n];
            step(v.ce, v.rst, v.i, v.ready);
            check($sformatf("t%0d_valid", n), v_a, v.ev);
            check($sformatf("t%0d_level", n), lvl_a, v.el);
            check($sformatf("t%0d_ovf", n), ovf_a, v.eo);
            check($sformatf("t%0d_noaddr", n), nad_a, v.en);
            check($sformatf("t%0d_level_b", n), lvl_b, v.el);
            if (v.ev || v.rst) begin
                check($sformatf("t%0d_addr", n), addr_a, v.ea);
                check($sformatf("t%0d_av", n), av_a, v.eav);
            end
        end

        // Invalid words interleaved with address-less records.
        step(1, 1, 10'h000, 0);
        step(1, 0, mk(8'h10, 0, 1), 0);
        step(1, 0, mk(8'h11, 1, 0), 0);
        step(1, 0, mk(8'h12, 0, 1), 0);
        step(1, 0, 10'h000, 0);
        step(1, 0, mk(8'h13, 1, 1), 0);
        step(1, 0, mk(8'h14, 0, 1), 0);
        step(1, 0, mk(8'h15, 0, 0), 0);
        check("stream_noaddr", nad_a, 3);
        check("stream_level", lvl_a, 4);
        order = '{8'h10, 8'h12, 8'h13, 8'h14};
        for (int k = 0; k < 4; k++) begin
            check($sformatf("stream_pop%0d", k), addr_a, order[k]);
            step(1, 0, 10'h000, 1);
        end
        check("stream_drained", v_a, 0);

        // Overflow saturation on the narrow instance, then a single reset cycle.
        step(1, 1, 10'h000, 0);
        for (int k = 0; k < 9; k++) step(1, 0, mk(8'(8'h40 + k), 1, 1), 0);
        check("sat_ovf_b", ovf_b, 3);
        check("sat_ovf_a", ovf_a, 5);
        step(1, 1, mk(8'h77, 1, 1), 1);
        check("rst_ovf_b", ovf_b, 0);
        check("rst_valid_b", v_b, 0);
        check("rst_addr_b", addr_b, 0);
        check("rst_level_b", lvl_b, 0);

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 79) == 0,
                 10'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/addr_record_receiver.md
ADDR_RECORD_RECEIVER -- requirements
Module: addr_record_receiver

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries; power of two, at least 2.
REQ-002 Parameter CNT_W, default 8, width of each statistics counter.
REQ-003 CLK  input  1  single clock; all state updates on posedge CLK.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 CE  input  1  clock enable; when 0, no state changes and the I word is ignored.
REQ-006 I  input  10  packed record: [9:2] address, [1] addressValid, [0] valid.
REQ-007 O_address  output  8  address field of head entry.
REQ-008 O_addressValid  output  1  addressValid field of head entry.
REQ-009 O_valid  output  1  head entry present (FIFO not empty).
REQ-010 O_ready  input  1  downstream accepts head entry when O_valid and O_ready are both 1.
REQ-011 level  output  log2(DEPTH)+1  current occupancy.
REQ-012 overflow_count  output  CNT_W  records dropped because the FIFO was full.
REQ-013 noaddr_count  output  CNT_W  accepted records with addressValid=0.

Function
REQ-014 Push condition: CE=1 and I[0]=1; the record is written as the new tail entry at that edge unless it is dropped per REQ-018.
REQ-015 I[0]=0 words are not stored and not counted.
REQ-016 Pop condition: CE=1, O_valid=1, O_ready=1; the head entry is removed at that edge.
REQ-017 Latency: a record pushed into an empty FIFO at edge n appears on O_* after edge n; there is no combinational bypass from I to O.
REQ-018 Full (level=DEPTH) with push and no pop: the record is dropped and overflow_count increments.
REQ-019 Full with simultaneous push and pop: the push is accepted, level is unchanged, and no overflow is counted.
REQ-020 Empty with pop request: the pop is ignored (O_valid=0), and O_address/O_addressValid are don't-care but stable.
REQ-021 Simultaneous push and pop while not empty and not full: level is unchanged, and ordering is strictly FIFO.
REQ-022 noaddr_count increments for each accepted (stored) record with I[1]=0; dropped records do not increment it.
REQ-023 Both counters saturate at 2^CNT_W-1 and never wrap.
REQ-024 Read and write pointers wrap modulo DEPTH; full/empty are derived from level, not from pointer equality alone.
REQ-025 Outputs O_* are driven from the registered storage head, so O_* are glitch-free relative to I.

Reset
REQ-026 When RESET=1 at an edge, regardless of CE: level=0, pointers=0, O_valid=0, O_address=0, O_addressValid=0, and both counters=0.
REQ-027 A reset asserted mid-stream discards all stored records, and the push/pop of that cycle are ignored.
REQ-028 The first push is accepted at the first edge with RESET=0.

Structure
REQ-029 A shared package holds RECORD_W=10, ADDR_MSB=9, ADDR_LSB=2, AV_BIT=1, V_BIT=0, and the record typedef; the matching packer module uses the same package.
REQ-030 Storage and pointers live in one sub-module, addr_record_fifo (DEPTH x 9 bits, push/pop/level); the top-level module holds the field decode and the counters.

Verification
REQ-031 Reset, then push I=10'h3FF -> next cycle O_valid=1, O_address=8'hFF, O_addressValid=1, level=1.
REQ-032 Push 5 records (addresses 1..5, addressValid=1) with O_ready=0, DEPTH=4 -> level=4, overflow_count=1, then pop order 1,2,3,4.
REQ-033 When full, push address 9 while popping -> level stays 4, overflow_count unchanged, and 9 is the last entry popped.
REQ-034 Stream with I[0]=0 words interleaved, plus 3 records with I[1]=0 -> only valid words are stored, noaddr_count=3.
REQ-035 CNT_W=2: 5 overflows -> overflow_count=3 (saturated); then assert RESET for 1 cycle -> all counters and outputs 0, O_valid=0.
REQ-036 Hold CE=0 for 3 cycles with pushes and pops pending -> no change to level, O_*, or counters.
